if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the OpenMIPS pipeline. Sits directly downstream of the instruction ROM, which test benches preload via `$readmemh`, and upstream of the decode stage. Owns the PC, the ROM chip-enable and address, and the IF/ID pipeline register. Handles stalls, delayed-branch redirects (including redirects that arrive during a stall), and exception flushes. Also maintains a fetch counter that benches can dump.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset and ROM enable.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `stall_if`  in  1  hold PC (and pending-branch state).
- `stall_id`  in  1  hold IF/ID register.
- `branch_flag`  in  1  decode resolved a taken branch/jump this cycle.
- `branch_target`  in  32  byte target address; bits [1:0] are forced to 0.
- `flush`  in  1  exception/eret redirect.
- `new_pc`  in  32  flush target; bits [1:0] are forced to 0.
- `rom_data`  in  32  combinational ROM read data for `rom_addr`.
- `rom_ce`  out  1  ROM chip enable.
- `rom_addr`  out  32  byte address, equal to the PC.
- `id_pc`  out  32  PC of the instruction in IF/ID.
- `id_inst`  out  32  instruction in IF/ID; 0 (nop) for a bubble.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  32  count of instructions delivered to ID.

## Operation
- Reset (`rst`=0, asynchronous), all registers cleared:
  - `rom_ce`=0, `rom_addr`=`RESET_PC`
  - `id_pc`=0, `id_inst`=0, `id_valid`=0
  - `fetch_count`=0, pending-branch flag cleared
- States are held in a 2-bit register:
  - IDLE: reset, `rom_ce`=0. Moves to RUN on the first edge after release.
  - RUN: normal fetch.
  - REDIR: a branch arrived under `stall_if`; the target is held in a pending register.
- While `rom_ce`=0, the PC stays at `RESET_PC` and IF/ID loads a bubble.
- Next-PC priority in RUN/REDIR:
  1. `flush`: PC <= `new_pc`; IF/ID <= bubble; pending cleared; go to RUN. Ignores both stalls.
  2. `stall_if`=1: PC is held. If `branch_flag`, pending <= `branch_target` and go to REDIR. A second branch while already in REDIR overwrites pending.
  3. REDIR and `stall_if`=0: PC <= pending target; go to RUN.
  4. `branch_flag`: PC <= `branch_target`.
  5. Otherwise: PC <= PC + 4, wrapping mod 2^32 (0xFFFF_FFFC -> 0).
- Delay slot: a branch does not flush IF/ID. The instruction fetched in the cycle `branch_flag` is high always proceeds to ID.
- IF/ID update, when not flushing:
  - `stall_id`=1: hold all IF/ID outputs.
  - `stall_if`=1 and `stall_id`=0: load a bubble (`id_inst`=0, `id_valid`=0; `id_pc` is held).
  - Otherwise: `id_pc` <= PC, `id_inst` <= `rom_data`, `id_valid` <= 1.
- `fetch_count` increments, with wrap, on every edge that loads IF/ID with `id_valid`=1.

## Timing
- ROM read is combinational; the IF-to-ID latency is 1 cycle.
- After `rst` rises:
  - Edge 1: `rom_ce` becomes 1, PC = `RESET_PC`.
  - Edge 2: `id_inst` = mem[0], `id_pc` = 0, PC = 4.
- Sustained throughput: one instruction per cycle with no stalls.
- Branch seen at edge N makes the PC equal the target after edge N. The target instruction reaches ID at edge N+1, following the delay slot.
- A pending branch (REDIR) takes effect on the first edge with `stall_if`=0. No cycle is lost beyond the stall itself.
- Asserting `rst` mid-operation clears all state immediately, not waiting for a clock edge.

## Test plan
- Reset and stream: ROM holds words 0x11..0x44 at addresses 0..12; release `rst` at t=20.
  - `id_inst` must read 0x11, 0x22, 0x33, 0x44 on consecutive cycles, with `id_pc` 0, 4, 8, 12.
  - After 4 instructions, `fetch_count`=4.
- Stall: hold `stall_if`=`stall_id`=1 for 3 cycles at PC=8.
  - `id_inst` stays mem[1] and the PC stays 8.
  - Fetch resumes with mem[2]; no instruction is skipped or duplicated.
- Bubble: `stall_if`=1, `stall_id`=0 for 1 cycle.
  - `id_inst`=0 and `id_valid`=0 for that cycle.
  - `fetch_count` does not increment.
- Branch: `branch_flag`=1, `branch_target`=0x40, while PC=8.
  - ID sequence must be mem[2] (delay slot) then mem[16].
  - `branch_target`=0x43 must behave identically to 0x40.
- Branch under stall and flush priority:
  - Branch to 0x20 during `stall_if`=1: the PC holds, then becomes 0x20 on the first unstalled edge.
  - `flush` with `new_pc`=0x100 in the same cycle as `branch_flag` and `stall_if`: the PC must be 0x100 and IF/ID must be a bubble.
- Wrap and async reset:
  - With the PC forced near 0xFFFF_FFFC, the PC must wrap to 0.
  - Pulling `rst` low between clock edges must zero all outputs immediately.

Source files
------------

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction ROM bus between the fetch stage and the ROM
interface if_stage_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    modport master (
        output rom_ce,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_ce,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, ROM access, IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    if_stage_if.master  rom,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] branch_target_w;
    logic [31:0] new_pc_w;

    // Redirect addresses are always word aligned
    assign branch_target_w = {branch_target[31:2], 2'b00};
    assign new_pc_w        = {new_pc[31:2], 2'b00};

    // State, PC, pending target and IF/ID register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pending_q     <= 32'h0;
            id_pc_q       <= 32'h0;
            id_inst_q     <= 32'h0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-PC selection, redirect bookkeeping and IF/ID load control
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_IDLE: begin
                // ROM not yet enabled: hold the reset PC and feed bubbles
                state_d    = S_RUN;
                pc_d       = RESET_PC;
                id_inst_d  = 32'h0;
                id_valid_d = 1'b0;
            end
            S_RUN, S_REDIR: begin
                if (flush) begin
                    // Exception redirect overrides both stalls and any pending branch
                    state_d    = S_RUN;
                    pc_d       = new_pc_w;
                    pending_d  = 32'h0;
                    id_inst_d  = 32'h0;
                    id_valid_d = 1'b0;
                end else begin
                    if (stall_if) begin
                        // PC frozen; remember a branch so it is not lost
                        if (branch_flag) begin
                            pending_d = branch_target_w;
                            state_d   = S_REDIR;
                        end
                    end else if (state_q == S_REDIR) begin
                        pc_d      = pending_q;
                        pending_d = 32'h0;
                        state_d   = S_RUN;
                    end else if (branch_flag) begin
                        pc_d = branch_target_w;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end

                    // Delay slot: the word fetched now always goes to ID
                    if (!stall_id) begin
                        if (stall_if) begin
                            id_inst_d  = 32'h0;
                            id_valid_d = 1'b0;
                        end else begin
                            id_pc_d       = pc_q;
                            id_inst_d     = rom.rom_data;
                            id_valid_d    = 1'b1;
                            fetch_count_d = fetch_count_q + 32'd1;
                        end
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                pc_d       = RESET_PC;
                pending_d  = 32'h0;
                id_inst_d  = 32'h0;
                id_valid_d = 1'b0;
            end
        endcase
    end

    assign rom.rom_ce   = (state_q != S_IDLE);
    assign rom.rom_addr = pc_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign id_valid     = id_valid_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed testbench for if_stage
module tb_if_stage;
    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    int pass_count;
    int check_count;

    if_stage_if romb ();

    assign romb.rom_data = mem[romb.rom_addr[9:2]];

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .rom           (romb.master),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        flush  = 1'b1;
        new_pc = target;
        step();
        flush  = 1'b0;
        new_pc = 32'h0;
    endtask

    task automatic test_reset();
        #2;
        check_count++; if (romb.rom_ce !== 1'b0) $display("FAIL reset_rom_ce: got %b want 0", romb.rom_ce); else pass_count++;
        check_count++; if (romb.rom_addr !== 32'h0) $display("FAIL reset_rom_addr: got %h want 00000000", romb.rom_addr); else pass_count++;
        check_count++; if (id_inst !== 32'h0 || id_pc !== 32'h0 || id_valid !== 1'b0) $display("FAIL reset_ifid: got pc=%h inst=%h v=%b want 0/0/0", id_pc, id_inst, id_valid); else pass_count++;
        check_count++; if (fetch_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", fetch_count); else pass_count++;
        #18;
        rst = 1'b1;
        step();
        check_count++; if (romb.rom_ce !== 1'b1 || romb.rom_addr !== 32'h0) $display("FAIL edge1: got ce=%b addr=%h want 1/00000000", romb.rom_ce, romb.rom_addr); else pass_count++;
        check_count++; if (id_valid !== 1'b0) $display("FAIL edge1_valid: got %b want 0", id_valid); else pass_count++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            step();
            check_count++; if (id_inst !== 32'h11 * (i + 1) || id_pc !== 32'(4 * i) || id_valid !== 1'b1) $display("FAIL stream_%0d: got inst=%h pc=%h v=%b want inst=%h pc=%h v=1", i, id_inst, id_pc, id_valid, 32'h11 * (i + 1), 4 * i); else pass_count++;
        end
        check_count++; if (fetch_count !== 32'd4) $display("FAIL stream_count: got %0d want 4", fetch_count); else pass_count++;
    endtask

    task automatic test_stall();
        redirect_to(32'h0);
        step();
        step();
        check_count++; if (romb.rom_addr !== 32'h8 || id_inst !== 32'h22) $display("FAIL stall_setup: got addr=%h inst=%h want 8/22", romb.rom_addr, id_inst); else pass_count++;
        stall_if = 1'b1;
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++; if (romb.rom_addr !== 32'h8 || id_inst !== 32'h22 || id_valid !== 1'b1) $display("FAIL stall_hold_%0d: got addr=%h inst=%h v=%b want 8/22/1", i, romb.rom_addr, id_inst, id_valid); else pass_count++;
        end
        stall_if = 1'b0;
        stall_id = 1'b0;
        step();
        check_count++; if (id_inst !== 32'h33 || id_pc !== 32'h8) $display("FAIL stall_resume: got inst=%h pc=%h want 33/8", id_inst, id_pc); else pass_count++;
        step();
        check_count++; if (id_inst !== 32'h44 || id_pc !== 32'hC) $display("FAIL stall_next: got inst=%h pc=%h want 44/c", id_inst, id_pc); else pass_count++;
        check_count++; if (fetch_count !== 32'd8) $display("FAIL stall_count: got %0d want 8", fetch_count); else pass_count++;
    endtask

    task automatic test_bubble();
        stall_if = 1'b1;
        stall_id = 1'b0;
        step();
        check_count++; if (id_inst !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'hC) $display("FAIL bubble: got inst=%h v=%b pc=%h want 0/0/c", id_inst, id_valid, id_pc); else pass_count++;
        check_count++; if (fetch_count !== 32'd8 || romb.rom_addr !== 32'h10) $display("FAIL bubble_hold: got count=%0d addr=%h want 8/10", fetch_count, romb.rom_addr); else pass_count++;
        stall_if = 1'b0;
        step();
        check_count++; if (id_inst !== 32'h1000_0004 || id_pc !== 32'h10 || fetch_count !== 32'd9) $display("FAIL bubble_resume: got inst=%h pc=%h count=%0d want 10000004/10/9", id_inst, id_pc, fetch_count); else pass_count++;
    endtask

    task automatic test_branch(input logic [31:0] target);
        redirect_to(32'h0);
        step();
        step();
        branch_flag   = 1'b1;
        branch_target = target;
        step();
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        check_count++; if (id_inst !== 32'h33 || id_pc !== 32'h8 || romb.rom_addr !== 32'h40) $display("FAIL branch_slot_%h: got inst=%h pc=%h addr=%h want 33/8/40", target, id_inst, id_pc, romb.rom_addr); else pass_count++;
        step();
        check_count++; if (id_inst !== 32'h1000_0010 || id_pc !== 32'h40 || romb.rom_addr !== 32'h44) $display("FAIL branch_target_%h: got inst=%h pc=%h addr=%h want 10000010/40/44", target, id_inst, id_pc, romb.rom_addr); else pass_count++;
    endtask

    task automatic test_branch_stall();
        stall_if      = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h20;
        step();
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        check_count++; if (romb.rom_addr !== 32'h44 || id_valid !== 1'b0) $display("FAIL bstall_hold: got addr=%h v=%b want 44/0", romb.rom_addr, id_valid); else pass_count++;
        step();
        check_count++; if (romb.rom_addr !== 32'h44) $display("FAIL bstall_hold2: got addr=%h want 44", romb.rom_addr); else pass_count++;
        stall_if = 1'b0;
        step();
        check_count++; if (romb.rom_addr !== 32'h20 || id_inst !== 32'h1000_0011 || id_pc !== 32'h44) $display("FAIL bstall_redirect: got addr=%h inst=%h pc=%h want 20/10000011/44", romb.rom_addr, id_inst, id_pc); else pass_count++;
        step();
        check_count++; if (id_inst !== 32'h1000_0008 || id_pc !== 32'h20) $display("FAIL bstall_target: got inst=%h pc=%h want 10000008/20", id_inst, id_pc); else pass_count++;
        // flush beats a simultaneous branch and both stalls
        flush         = 1'b1;
        new_pc        = 32'h100;
        branch_flag   = 1'b1;
        branch_target = 32'h20;
        stall_if      = 1'b1;
        stall_id      = 1'b1;
        step();
        flush = 1'b0; new_pc = 32'h0; branch_flag = 1'b0; branch_target = 32'h0; stall_if = 1'b0; stall_id = 1'b0;
        check_count++; if (romb.rom_addr !== 32'h100 || id_inst !== 32'h0 || id_valid !== 1'b0) $display("FAIL flush_prio: got addr=%h inst=%h v=%b want 100/0/0", romb.rom_addr, id_inst, id_valid); else pass_count++;
        step();
        check_count++; if (id_inst !== 32'h1000_0040 || id_pc !== 32'h100 || romb.rom_addr !== 32'h104) $display("FAIL flush_after: got inst=%h pc=%h addr=%h want 10000040/100/104", id_inst, id_pc, romb.rom_addr); else pass_count++;
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFF9);
        check_count++; if (romb.rom_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_align: got %h want fffffff8", romb.rom_addr); else pass_count++;
        step();
        step();
        check_count++; if (romb.rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_inst !== 32'h1000_00FF) $display("FAIL wrap: got addr=%h pc=%h inst=%h want 0/fffffffc/100000ff", romb.rom_addr, id_pc, id_inst); else pass_count++;
        step();
        check_count++; if (id_pc !== 32'h0 || id_inst !== 32'h11) $display("FAIL wrap_next: got pc=%h inst=%h want 0/11", id_pc, id_inst); else pass_count++;
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        check_count++; if (romb.rom_ce !== 1'b0 || romb.rom_addr !== 32'h0) $display("FAIL async_rom: got ce=%b addr=%h want 0/0", romb.rom_ce, romb.rom_addr); else pass_count++;
        check_count++; if (id_pc !== 32'h0 || id_inst !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 32'h0) $display("FAIL async_ifid: got pc=%h inst=%h v=%b count=%0d want all 0", id_pc, id_inst, id_valid, fetch_count); else pass_count++;
        #2;
        rst = 1'b1;
        step();
        check_count++; if (romb.rom_ce !== 1'b1 || id_valid !== 1'b0) $display("FAIL restart_edge1: got ce=%b v=%b want 1/0", romb.rom_ce, id_valid); else pass_count++;
        step();
        check_count++; if (id_inst !== 32'h11 || id_pc !== 32'h0 || romb.rom_addr !== 32'h4) $display("FAIL restart_edge2: got inst=%h pc=%h addr=%h want 11/0/4", id_inst, id_pc, romb.rom_addr); else pass_count++;
    endtask

    initial begin
        pass_count    = 0;
        check_count   = 0;
        rst           = 1'b0;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        flush         = 1'b0;
        new_pc        = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_branch(32'h40);
        test_branch(32'h43);
        test_branch_stall();
        test_wrap();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
